// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int         BCD_DIGIT_W = 4;
    localparam logic [3:0] ADD3_THRESH = 4'd5;
    localparam logic [3:0] ADD3_VAL    = 4'd3;

endpackage

// File: rtl/bcd_add3.sv
// Per-digit double-dabble correction: digits of 5 or more get +3 before the shift.
module bcd_add3
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] d_i,
    output logic [BCD_DIGIT_W-1:0] d_o
);

    // Add-3 correction, modulo 16.
    always_comb begin
        if (d_i >= ADD3_THRESH) begin
            d_o = d_i + ADD3_VAL;
        end else begin
            d_o = d_i;
        end
    end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter with start/busy/done handshake.
// Optional leading-zero blanking output enabled by defining BCD_LZB_EN.
module bin_to_bcd_seq #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                START,
    input  logic [BIN_W-1:0]    BIN,
    output logic                BUSY,
    output logic                DONE,
    output logic [4*DIGITS-1:0] BCD
`ifdef BCD_LZB_EN
    ,
    output logic [DIGITS-1:0]   BLANK
`endif
);
    import bcd_pkg::*;

    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam int SCR_W = BCD_DIGIT_W * DIGITS;

    // The state literal DONE is shadowed by the port, so states are package-qualified.
    bcd_pkg::state_t  state_q, state_d;
    logic [BIN_W-1:0] shift_q, shift_d;
    logic [SCR_W-1:0] scratch_q, scratch_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SCR_W-1:0] bcd_q, bcd_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [SCR_W-1:0] corr_s;
    logic [SCR_W-1:0] scr_shift_s;

    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .d_i (scratch_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .d_o (corr_s[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    // Corrected scratch shifted left, taking in the next binary MSB.
    always_comb begin
        scr_shift_s = SCR_W'({corr_s, shift_q[BIN_W-1]});
    end

`ifdef BCD_LZB_EN
    logic [DIGITS-1:0] blank_q, blank_d, blank_s;
    logic              nz_s;

    // A digit is blanked when it and every higher digit are zero; units never blank.
    always_comb begin
        nz_s    = 1'b0;
        blank_s = '0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            nz_s       = nz_s | (|scr_shift_s[i*BCD_DIGIT_W +: BCD_DIGIT_W]);
            blank_s[i] = ~nz_s;
        end
    end
`endif

    // Next-state and datapath control for IDLE -> SHIFT x BIN_W -> DONE.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        bcd_d     = bcd_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
`ifdef BCD_LZB_EN
        blank_d   = blank_q;
`endif
        case (state_q)
            bcd_pkg::IDLE: begin
                if (START) begin
                    shift_d   = BIN;
                    scratch_d = '0;
                    cnt_d     = CNT_W'(BIN_W);
                    busy_d    = 1'b1;
                    state_d   = bcd_pkg::SHIFT;
                end else begin
                    state_d   = bcd_pkg::IDLE;
                end
            end
            bcd_pkg::SHIFT: begin
                scratch_d = scr_shift_s;
                shift_d   = shift_q << 1;
                cnt_d     = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    // Result and pulse are registered so both appear in the DONE cycle.
                    state_d = bcd_pkg::DONE;
                    done_d  = 1'b1;
                    bcd_d   = scr_shift_s;
`ifdef BCD_LZB_EN
                    blank_d = blank_s;
`endif
                end else begin
                    state_d = bcd_pkg::SHIFT;
                end
            end
            bcd_pkg::DONE: begin
                state_d = bcd_pkg::IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = bcd_pkg::IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q   <= bcd_pkg::IDLE;
            shift_q   <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            bcd_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef BCD_LZB_EN
            blank_q   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            bcd_q     <= bcd_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef BCD_LZB_EN
            blank_q   <= blank_d;
`endif
        end
    end

    assign BUSY = busy_q;
    assign DONE = done_q;
    assign BCD  = bcd_q;
`ifdef BCD_LZB_EN
    assign BLANK = blank_q;
`endif

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: directed corner cases plus random values
// checked against an arithmetic decimal model (covers BLANK when BCD_LZB_EN is defined).
module tb_bin_to_bcd_seq;

    localparam int BIN_W  = 8;
    localparam int DIGITS = 3;

    logic                CLK;
    logic                RST_N;
    logic                START;
    logic [BIN_W-1:0]    BIN;
    logic                BUSY;
    logic                DONE;
    logic [4*DIGITS-1:0] BCD;
`ifdef BCD_LZB_EN
    logic [DIGITS-1:0]   BLANK;
`endif

    int n_checks = 0;
    int n_errors = 0;

    bin_to_bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .START (START),
        .BIN   (BIN),
        .BUSY  (BUSY),
        .DONE  (DONE),
        .BCD   (BCD)
`ifdef BCD_LZB_EN
        ,
        .BLANK (BLANK)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Decimal digits by division, packed units-first.
    function automatic logic [31:0] model_bcd(input int v);
        logic [31:0] r;
        int p;
        r = 32'd0;
        p = 1;
        for (int i = 0; i < DIGITS; i++) begin
            r[i*4 +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    // Digit i (i>=1) is blank when the value is below 10**i.
    function automatic logic [31:0] model_blank(input int v);
        logic [31:0] r;
        int p;
        r = 32'd0;
        p = 10;
        for (int i = 1; i < DIGITS; i++) begin
            r[i] = (v < p);
            p = p * 10;
        end
        return r;
    endfunction

    task automatic wait_done(output int lat);
        lat = 0;
        while (!DONE && lat < 3 * BIN_W) begin
            tick();
            lat++;
        end
    endtask

    task automatic convert(input int v);
        int lat;
        BIN   = BIN_W'(v);
        START = 1'b1;
        tick();
        START = 1'b0;
        chk("busy_after_start", 32'(BUSY), 32'd1);
        BIN = BIN_W'($urandom);
        wait_done(lat);
        chk("latency", 32'(lat), 32'(BIN_W));
        chk("bcd_value", 32'(BCD), model_bcd(v));
`ifdef BCD_LZB_EN
        chk("blank_value", 32'(BLANK), model_blank(v));
`endif
        tick();
        chk("done_one_cycle", 32'(DONE), 32'd0);
        chk("busy_cleared", 32'(BUSY), 32'd0);
    endtask

    initial begin
        int t;
        int pulses;
        int t_first;
        int t_second;
        logic [31:0] r_first;
        logic [31:0] r_second;
        int v;

        RST_N = 1'b0;
        START = 1'b0;
        BIN   = '0;
        tick();
        tick();
        chk("reset_busy", 32'(BUSY), 32'd0);
        chk("reset_done", 32'(DONE), 32'd0);
        chk("reset_bcd", 32'(BCD), 32'd0);
`ifdef BCD_LZB_EN
        chk("reset_blank", 32'(BLANK), 32'd0);
`endif
        RST_N = 1'b1;
        tick();

        convert(0);
        convert(255);
        convert(99);
        convert(100);
        convert(7);
        convert(105);
        convert(40);

        // Result holds while idle even as BIN changes.
        for (int i = 0; i < 4; i++) begin
            BIN = BIN_W'($urandom);
            tick();
        end
        chk("bcd_hold", 32'(BCD), model_bcd(40));

        // START held high: back-to-back conversions, BIN changed while busy.
        BIN      = 8'd42;
        START    = 1'b1;
        tick();
        BIN      = 8'd137;
        pulses   = 0;
        t_first  = 0;
        t_second = 0;
        r_first  = 32'd0;
        r_second = 32'd0;
        for (t = 1; t <= 24; t++) begin
            tick();
            if (DONE) begin
                pulses++;
                if (pulses == 1) begin
                    t_first = t;
                    r_first = 32'(BCD);
                end else begin
                    t_second = t;
                    r_second = 32'(BCD);
                    START    = 1'b0;
                end
            end
        end
        START = 1'b0;
        chk("b2b_pulses", 32'(pulses), 32'd2);
        chk("b2b_first", r_first, model_bcd(42));
        chk("b2b_second", r_second, model_bcd(137));
        chk("b2b_spacing", 32'(t_second - t_first), 32'(BIN_W + 2));
        tick();
        tick();

        // START during SHIFT is ignored, not queued.
        BIN   = 8'd200;
        START = 1'b1;
        tick();
        START = 1'b0;
        tick();
        tick();
        BIN   = 8'd7;
        START = 1'b1;
        tick();
        START = 1'b0;
        pulses = 0;
        r_first = 32'd0;
        for (t = 0; t < 25; t++) begin
            tick();
            if (DONE) begin
                pulses++;
                r_first = 32'(BCD);
            end
        end
        chk("ignore_pulses", 32'(pulses), 32'd1);
        chk("ignore_value", r_first, model_bcd(200));

        // Reset mid-SHIFT aborts without a DONE pulse.
        BIN   = 8'd123;
        START = 1'b1;
        tick();
        START = 1'b0;
        tick();
        tick();
        tick();
        RST_N = 1'b0;
        tick();
        RST_N = 1'b1;
        chk("abort_bcd", 32'(BCD), 32'd0);
        chk("abort_busy", 32'(BUSY), 32'd0);
        chk("abort_done", 32'(DONE), 32'd0);
        pulses = 0;
        for (t = 0; t < 15; t++) begin
            tick();
            if (DONE) pulses++;
        end
        chk("abort_no_done", 32'(pulses), 32'd0);
        convert(58);

        // Random values against the decimal model.
        for (int i = 0; i < 25; i++) begin
            v = int'($urandom_range(0, (1 << BIN_W) - 1));
            convert(v);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
